mem_access: RTL and testbench

- Memory-access (MEM) stage that sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Turns the registered memory request (address, store data, write enable, op) into a req/ack data-bus transaction, with byte-lane steering and load sign/zero extension.
- Holds the pipeline through `stall_req_o` until the access completes, then presents the final register write-back triple.
- Flags misaligned accesses and bus time-outs.

---
 rtl/mem_access_pkg.sv | 32 +++
 rtl/mem_align.sv | 58 +++++
 rtl/mem_access.sv | 129 ++++++++++++
 tb/tb_mem_access.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
`default_nettype none
// mem_access_pkg: shared widths, memory op codes, FSM state type and op helpers for the MEM stage.
package mem_access_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 32;
  localparam int RDATA_WIDTH = 32;
  localparam int RADDR_WIDTH = 5;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// mem_align: byte-lane enables, store replication, misalign check and load extraction/extension.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [3:0]            op_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [DATA_WIDTH-1:0] sdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [3:0]            be_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  misalign_o,
  output logic [DATA_WIDTH-1:0] ldata_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      2'd3:    w_byte = rdata_i[31:24];
      default: w_byte = rdata_i[7:0];
    endcase
    w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = sdata_i;
    misalign_o = 1'b0;
    ldata_o    = '0;
    case (op_i)
      MEM_LB, MEM_LBU, MEM_SB: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{sdata_i[7:0]}};
        ldata_o = (op_i == MEM_LB) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{sdata_i[15:0]}};
        misalign_o = addr_lo_i[0];
        ldata_o    = (op_i == MEM_LH) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      end
      MEM_LW, MEM_SW: begin
        be_o       = 4'b1111;
        wdata_o    = sdata_i;
        misalign_o = (addr_lo_i != 2'b00);
        ldata_o    = rdata_i;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// mem_access: MEM pipeline stage; req/ack data-bus FSM with stall, ack time-out and write-back select.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic                   mem_we_i,
  input  logic [3:0]             mem_op_i,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [RDATA_WIDTH-1:0] reg_wdata_o,
  output logic                   dbus_req_o,
  output logic                   dbus_we_o,
  output logic [31:0]            dbus_addr_o,
  output logic [3:0]             dbus_be_o,
  output logic [31:0]            dbus_wdata_o,
  input  logic [31:0]            dbus_rdata_i,
  input  logic                   dbus_ack_i,
  output logic                   stall_req_o,
  output logic                   misalign_o,
  output logic                   bus_err_o
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e                 r_state, w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [RDATA_WIDTH-1:0] r_result;
  logic                   r_err;
  logic                   r_req;

  logic                   w_access, w_misalign, w_timeout, w_ack;
  logic [3:0]             w_be;
  logic [DATA_WIDTH-1:0]  w_wdata, w_ldata;

  mem_align u_align (
    .op_i       (mem_op_i),
    .addr_lo_i  (mem_addr_i[1:0]),
    .sdata_i    (mem_data_i),
    .rdata_i    (dbus_rdata_i),
    .be_o       (w_be),
    .wdata_o    (w_wdata),
    .misalign_o (w_misalign),
    .ldata_o    (w_ldata)
  );

  assign w_access  = (mem_op_i != MEM_NOP);
  assign w_ack     = (r_state == ST_BUSY) && dbus_ack_i;
  // Ack has priority over a time-out landing in the same cycle.
  assign w_timeout = (r_state == ST_BUSY) && !dbus_ack_i && (r_cnt == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_req    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_req   <= (w_next == ST_BUSY);
      r_cnt   <= (r_state == ST_BUSY) ? r_cnt + 1'b1 : '0;
      if (w_ack) begin
        r_result <= w_ldata;
        r_err    <= 1'b0;
      end else if (w_timeout) begin
        r_result <= '0;
        r_err    <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    stall_req_o = 1'b0;
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;
    reg_waddr_o = reg_waddr_i;
    reg_wdata_o = reg_wdata_i;
    reg_we_o    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_access) begin
          reg_we_o = reg_we_i;
        end else if (w_misalign) begin
          misalign_o = 1'b1;
        end else begin
          stall_req_o = 1'b1;
          w_next      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_req_o = 1'b1;
        bus_err_o   = w_timeout;
        if (w_ack || w_timeout) w_next = ST_DONE;
      end
      ST_DONE: begin
        if (is_load(mem_op_i)) reg_wdata_o = r_result;
        reg_we_o = reg_we_i && !r_err;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // Reset must quiet the pipeline-facing strobes even though they are combinational.
    if (!rst_n_i) begin
      stall_req_o = 1'b0;
      misalign_o  = 1'b0;
      bus_err_o   = 1'b0;
      reg_we_o    = 1'b0;
    end
  end

  assign dbus_req_o   = r_req;
  assign dbus_we_o    = mem_we_i;
  assign dbus_addr_o  = {mem_addr_i[31:2], 2'b00};
  assign dbus_be_o    = r_req ? w_be : 4'b0000;
  assign dbus_wdata_o = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// tb_mem_access: directed self-checking bench for the MEM stage (ACK_TIMEOUT = 4).
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [4:0]  reg_waddr_i = '0;
  logic        reg_we_i = 1'b0;
  logic [31:0] reg_wdata_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_op_i = MEM_NOP;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_rdata_i = '0;
  logic        dbus_ack_i = 1'b0;
  logic        stall_req_o, misalign_o, bus_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access #(.ACK_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_we_i(mem_we_i), .mem_op_i(mem_op_i),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i),
    .stall_req_o(stall_req_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    reg_we_i = 1'b1; reg_wdata_i = 32'h5555_5555; reg_waddr_i = 5'd7;
    mem_op_i = op; mem_addr_i = addr; mem_we_i = 1'b0;
    #2;
    check({tag, "_idle_stall"}, {31'd0, stall_req_o}, 32'd1);
    tick();
    dbus_ack_i = 1'b1; dbus_rdata_i = rdata;
    #2;
    check({tag, "_busy_req"}, {31'd0, dbus_req_o}, 32'd1);
    check({tag, "_busy_stall"}, {31'd0, stall_req_o}, 32'd1);
    tick();
    dbus_ack_i = 1'b0;
    #2;
    check({tag, "_done_stall"}, {31'd0, stall_req_o}, 32'd0);
    check({tag, "_done_wdata"}, reg_wdata_o, exp);
    check({tag, "_done_we"}, {31'd0, reg_we_o}, 32'd1);
    tick();
    mem_op_i = MEM_NOP;
    #2;
  endtask

  initial begin
    reg_we_i = 1'b1;
    #3;
    check("rst_req", {31'd0, dbus_req_o}, 32'd0);
    check("rst_stall", {31'd0, stall_req_o}, 32'd0);
    check("rst_we", {31'd0, reg_we_o}, 32'd0);
    check("rst_flags", {30'd0, misalign_o, bus_err_o}, 32'd0);
    tick();
    rst_n_i = 1'b1;
    tick();

    // Pass-through with no access
    reg_we_i = 1'b1; reg_waddr_i = 5'd9; reg_wdata_i = 32'hCAFE_0001; mem_op_i = MEM_NOP;
    #2;
    check("nop_waddr", {27'd0, reg_waddr_o}, 32'd9);
    check("nop_wdata", reg_wdata_o, 32'hCAFE_0001);
    check("nop_we", {31'd0, reg_we_o}, 32'd1);
    check("nop_stall", {31'd0, stall_req_o}, 32'd0);
    tick();

    run_load("lw",  MEM_LW,  32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_load("lb",  MEM_LB,  32'h0000_0103, 32'h80AB_CDEF, 32'hFFFF_FF80);
    run_load("lbu", MEM_LBU, 32'h0000_0103, 32'h80AB_CDEF, 32'h0000_0080);
    run_load("lh",  MEM_LH,  32'h0000_0102, 32'h9234_5678, 32'hFFFF_9234);
    run_load("lhu", MEM_LHU, 32'h0000_0100, 32'h1234_8765, 32'h0000_8765);
    run_load("lb1", MEM_LB,  32'h0000_0101, 32'h1122_7F44, 32'h0000_007F);

    // SH at 0x102
    reg_we_i = 1'b0; reg_wdata_i = 32'h0000_0102;
    mem_op_i = MEM_SH; mem_addr_i = 32'h0000_0102; mem_data_i = 32'h1234_ABCD; mem_we_i = 1'b1;
    #2;
    check("sh_idle_be", {28'd0, dbus_be_o}, 32'd0);
    tick();
    dbus_ack_i = 1'b1;
    #2;
    check("sh_be", {28'd0, dbus_be_o}, 32'hC);
    check("sh_wdata", dbus_wdata_o, 32'hABCD_ABCD);
    check("sh_we", {31'd0, dbus_we_o}, 32'd1);
    check("sh_addr", dbus_addr_o, 32'h0000_0100);
    tick();
    dbus_ack_i = 1'b0;
    #2;
    check("sh_done_wdata", reg_wdata_o, 32'h0000_0102);
    check("sh_done_we", {31'd0, reg_we_o}, 32'd0);
    tick();
    mem_op_i = MEM_NOP; mem_we_i = 1'b0;

    // SB replication and lane
    mem_op_i = MEM_SB; mem_addr_i = 32'h0000_0201; mem_data_i = 32'h0000_0077; mem_we_i = 1'b1;
    tick();
    dbus_ack_i = 1'b1;
    #2;
    check("sb_be", {28'd0, dbus_be_o}, 32'h2);
    check("sb_wdata", dbus_wdata_o, 32'h7777_7777);
    tick();
    dbus_ack_i = 1'b0;
    tick();
    mem_op_i = MEM_NOP; mem_we_i = 1'b0;

    // Misaligned LW
    reg_we_i = 1'b1;
    mem_op_i = MEM_LW; mem_addr_i = 32'h0000_0101;
    #2;
    check("mis_pulse", {31'd0, misalign_o}, 32'd1);
    check("mis_stall", {31'd0, stall_req_o}, 32'd0);
    check("mis_we", {31'd0, reg_we_o}, 32'd0);
    tick();
    check("mis_noreq", {31'd0, dbus_req_o}, 32'd0);
    mem_op_i = MEM_NOP;
    tick();

    // Time-out with ack withheld
    mem_op_i = MEM_LW; mem_addr_i = 32'h0000_0200;
    tick();
    for (int i = 1; i <= 4; i++) begin
      #2;
      check($sformatf("tmo_err_c%0d", i), {31'd0, bus_err_o}, (i == 4) ? 32'd1 : 32'd0);
      tick();
    end
    #2;
    check("tmo_done_we", {31'd0, reg_we_o}, 32'd0);
    check("tmo_done_wdata", reg_wdata_o, 32'd0);
    check("tmo_done_err", {31'd0, bus_err_o}, 32'd0);
    tick();
    mem_op_i = MEM_NOP;
    #2;
    check("tmo_idle_stall", {31'd0, stall_req_o}, 32'd0);
    check("tmo_idle_req", {31'd0, dbus_req_o}, 32'd0);
    tick();

    // Reset in BUSY, then a stray ack
    mem_op_i = MEM_LW; mem_addr_i = 32'h0000_0300;
    tick();
    #2;
    check("rb_req", {31'd0, dbus_req_o}, 32'd1);
    rst_n_i = 1'b0;
    #1;
    check("rb_req_drop", {31'd0, dbus_req_o}, 32'd0);
    check("rb_we", {31'd0, reg_we_o}, 32'd0);
    mem_op_i = MEM_NOP; reg_we_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h1111_1111;
    tick();
    dbus_ack_i = 1'b0;
    #2;
    check("rb_stray_stall", {31'd0, stall_req_o}, 32'd0);
    check("rb_stray_req", {31'd0, dbus_req_o}, 32'd0);
    check("rb_stray_we", {31'd0, reg_we_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
